// File: rtl/assembly_line_sequencer.sv
// Sequences mnemonic/register/immediate interpreters across one ASCII source line
// and emits one decoded or error record per newline-terminated line.
module assembly_line_sequencer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        char_valid,
  input  logic [7:0]  char_in,
  output logic        char_ready,
  output logic [7:0]  fwd_ascii,
  output logic        fwd_new_char,
  output logic        inst_valid_data,
  output logic        reg_valid_data,
  output logic        imm_valid_data,
  input  logic        inst_done,
  input  logic        inst_error,
  input  logic [6:0]  inst_opcode,
  input  logic [6:0]  inst_funct7,
  input  logic [2:0]  inst_funct3,
  input  logic        reg_done,
  input  logic        reg_error,
  input  logic [4:0]  reg_index,
  input  logic        imm_done,
  input  logic        imm_error,
  input  logic [31:0] imm_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_error,
  output logic [2:0]  err_code,
  output logic [6:0]  opcode,
  output logic [6:0]  funct7,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [15:0] line_count
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NL    = 8'h0A;

  typedef enum logic [2:0] {S_INST, S_OPND, S_WAIT, S_TAIL, S_DRAIN, S_OUT} state_t;
  typedef enum logic [1:0] {K_RD, K_RS1, K_RS2, K_IMM} kind_t;

  // Operand count per opcode; zero marks an opcode with no schedule.
  function automatic logic [1:0] num_slots(input logic [6:0] op);
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: num_slots = 2'd3;
      OP_JAL, OP_LUI, OP_AUIPC:                              num_slots = 2'd2;
      default:                                               num_slots = 2'd0;
    endcase
  endfunction

  function automatic kind_t kind_of(input logic [6:0] op, input logic [1:0] slot_idx);
    logic [5:0] lst;
    case (op)
      OP_REG:                    lst = {K_RS2, K_RS1, K_RD};
      OP_IMM, OP_LOAD, OP_JALR:  lst = {K_IMM, K_RS1, K_RD};
      OP_STORE:                  lst = {K_IMM, K_RS1, K_RS2};
      OP_BRANCH:                 lst = {K_IMM, K_RS2, K_RS1};
      default:                   lst = {K_RD,  K_IMM, K_RD};
    endcase
    case (slot_idx)
      2'd0:    kind_of = kind_t'(lst[1:0]);
      2'd1:    kind_of = kind_t'(lst[3:2]);
      default: kind_of = kind_t'(lst[5:4]);
    endcase
  endfunction

  state_t      state, state_n;
  logic        started, started_n;
  logic        term_nl, term_nl_n;
  logic        mnem, mnem_n;
  logic [1:0]  slot, slot_n;
  logic        err_n;
  logic [2:0]  code_n;
  logic [6:0]  opcode_n, funct7_n;
  logic [2:0]  funct3_n;
  logic [4:0]  rd_n, rs1_n, rs2_n;
  logic [31:0] imm_n;
  logic [15:0] line_n;

  kind_t       cur_kind;
  logic        last_slot;
  logic        is_nl, is_sep, is_term, accept;
  logic        fdone, ferr, fail;
  logic [2:0]  fail_code;

  assign is_nl   = (char_in == CH_NL);
  assign is_sep  = (char_in == CH_SP) || (char_in == CH_COMMA);
  assign is_term = is_nl || is_sep;

  assign char_ready   = !rst_in && (state == S_INST || state == S_OPND ||
                                    state == S_TAIL || state == S_DRAIN);
  assign accept       = char_valid && char_ready;
  assign fwd_new_char = accept;
  assign fwd_ascii    = rst_in ? 8'd0 : char_in;
  assign out_valid    = !rst_in && (state == S_OUT);

  assign cur_kind  = kind_of(opcode, slot);
  assign last_slot = (slot == num_slots(opcode) - 2'd1);

  // Selects are live only in INST/OPND, so each interpreter is held idle through WAIT.
  assign inst_valid_data = !rst_in && (state == S_INST);
  assign reg_valid_data  = !rst_in && (state == S_OPND) && (cur_kind != K_IMM);
  assign imm_valid_data  = !rst_in && (state == S_OPND) && (cur_kind == K_IMM);

  always_comb begin
    state_n   = state;
    started_n = started;
    term_nl_n = term_nl;
    mnem_n    = mnem;
    slot_n    = slot;
    err_n     = out_error;
    code_n    = err_code;
    opcode_n  = opcode;
    funct3_n  = funct3;
    funct7_n  = funct7;
    rd_n      = rd;
    rs1_n     = rs1;
    rs2_n     = rs2;
    imm_n     = imm;
    line_n    = line_count;
    fail      = 1'b0;
    fail_code = 3'd0;
    fdone     = (cur_kind == K_IMM) ? imm_done  : reg_done;
    ferr      = (cur_kind == K_IMM) ? imm_error : reg_error;

    case (state)
      S_INST: begin
        if (accept) begin
          if (!is_term) begin
            started_n = 1'b1;
          end else if (started) begin
            started_n = 1'b0;
            term_nl_n = is_nl;
            mnem_n    = 1'b1;
            state_n   = S_WAIT;
          end
        end
      end
      S_OPND: begin
        if (accept) begin
          if (!is_term) begin
            started_n = 1'b1;
          end else if (started) begin
            started_n = 1'b0;
            term_nl_n = is_nl;
            mnem_n    = 1'b0;
            state_n   = S_WAIT;
          end else if (is_nl) begin
            err_n   = 1'b1;
            code_n  = 3'd4;
            state_n = S_OUT;
          end
        end
      end
      S_WAIT: begin
        if (mnem) begin
          if (inst_done) begin
            opcode_n = inst_opcode;
            funct3_n = inst_funct3;
            funct7_n = inst_funct7;
            if (num_slots(inst_opcode) == 2'd0) begin
              fail = 1'b1; fail_code = 3'd7;
            end else if (term_nl) begin
              fail = 1'b1; fail_code = 3'd4;
            end else begin
              slot_n  = 2'd0;
              state_n = S_OPND;
            end
          end else if (inst_error) begin
            fail = 1'b1; fail_code = 3'd1;
          end else begin
            fail = 1'b1; fail_code = 3'd7;
          end
        end else begin
          if (fdone) begin
            case (cur_kind)
              K_RD:    rd_n  = reg_index;
              K_RS1:   rs1_n = reg_index;
              K_RS2:   rs2_n = reg_index;
              default: imm_n = imm_value;
            endcase
            if (last_slot) begin
              state_n = term_nl ? S_OUT : S_TAIL;
            end else if (term_nl) begin
              fail = 1'b1; fail_code = 3'd4;
            end else begin
              slot_n  = slot + 2'd1;
              state_n = S_OPND;
            end
          end else if (ferr) begin
            fail = 1'b1; fail_code = (cur_kind == K_IMM) ? 3'd3 : 3'd2;
          end else begin
            fail = 1'b1; fail_code = 3'd7;
          end
        end
      end
      S_TAIL: begin
        if (accept) begin
          if (is_nl) begin
            state_n = S_OUT;
          end else if (!is_sep) begin
            err_n   = 1'b1;
            code_n  = 3'd5;
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept && is_nl) state_n = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          line_n    = line_count + 16'd1;
          err_n     = 1'b0;
          code_n    = 3'd0;
          opcode_n  = 7'd0;
          funct3_n  = 3'd0;
          funct7_n  = 7'd0;
          rd_n      = 5'd0;
          rs1_n     = 5'd0;
          rs2_n     = 5'd0;
          imm_n     = 32'd0;
          slot_n    = 2'd0;
          started_n = 1'b0;
          state_n   = S_INST;
        end
      end
      default: state_n = S_INST;
    endcase

    // An error on a newline-terminated field has nothing left to drain.
    if (fail) begin
      err_n   = 1'b1;
      code_n  = fail_code;
      state_n = term_nl ? S_OUT : S_DRAIN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_INST;
      started    <= 1'b0;
      term_nl    <= 1'b0;
      mnem       <= 1'b0;
      slot       <= 2'd0;
      out_error  <= 1'b0;
      err_code   <= 3'd0;
      opcode     <= 7'd0;
      funct3     <= 3'd0;
      funct7     <= 7'd0;
      rd         <= 5'd0;
      rs1        <= 5'd0;
      rs2        <= 5'd0;
      imm        <= 32'd0;
      line_count <= 16'd0;
    end else begin
      state      <= state_n;
      started    <= started_n;
      term_nl    <= term_nl_n;
      mnem       <= mnem_n;
      slot       <= slot_n;
      out_error  <= err_n;
      err_code   <= code_n;
      opcode     <= opcode_n;
      funct3     <= funct3_n;
      funct7     <= funct7_n;
      rd         <= rd_n;
      rs1        <= rs1_n;
      rs2        <= rs2_n;
      imm        <= imm_n;
      line_count <= line_n;
    end
  end

endmodule
